// File: rtl/iir_out_decim_pkg.sv
// ---------------------------------------------------------------------------
// iir_out_decim_pkg
//
// Shared definitions for the filter output stage and its FIFO:
//   clog2     - constant ceil(log2) used to size counters, pointers and the
//               accumulator growth bits
//   sat_max   - largest value representable in a signed word of a given width
//   sat_min   - smallest value representable in a signed word of a given width
//
// The saturation helpers return 64-bit values so callers can cast them to
// whatever internal width they compare against.
// ---------------------------------------------------------------------------
package iir_out_decim_pkg;

    // Ceil(log2(value)); clog2(1) = 0 so a decimation factor of one adds no
    // accumulator growth and no shift.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Upper clamp limit for a signed word of the given width.
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Lower clamp limit for a signed word of the given width.
    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/iir_sync_fifo.sv
// ---------------------------------------------------------------------------
// iir_sync_fifo
//
// Single-clock first-word-fall-through FIFO used to buffer decimated samples.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset (empties the FIFO, clears dout)
//   push   write din this cycle; ignored when full unless a pop happens on
//          the same edge
//   pop    remove the head entry; ignored when empty
//   din    write data
//   dout   head-of-FIFO data; holds its last value while the FIFO is empty
//   count  number of stored entries (one bit wider than the pointers so
//          full and empty are distinguishable)
//   full   count == DEPTH
//   empty  count == 0
// ---------------------------------------------------------------------------
module iir_sync_fifo
    import iir_out_decim_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty
);

    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] COUNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0] COUNT_ONE  = (PW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic [WIDTH-1:0] r_dout;

    logic             w_do_push;
    logic             w_do_pop;
    logic [PW-1:0]    w_rd_next;

    assign empty     = (r_count == '0);
    assign full      = (r_count == COUNT_FULL);
    assign w_do_pop  = pop && !empty;
    // A pop on the same edge frees the slot the push needs, so a full FIFO
    // still accepts the write in that case.
    assign w_do_push = push && (!full || w_do_pop);
    assign w_rd_next = r_rd_ptr + 1'b1;

    assign count = r_count;
    assign dout  = r_dout;

    // Storage carries no reset: its contents are only meaningful behind the
    // pointers, which are reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Registered head word. When more than one entry is stored, the entry
    // behind the head becomes visible after a pop. When the FIFO is empty,
    // or its only entry is being popped, a pushed word goes straight to the
    // head. Otherwise the head holds, which also keeps the last value
    // visible after the FIFO drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
        end else if (w_do_pop && (r_count > COUNT_ONE)) begin
            r_dout <= r_mem[w_rd_next];
        end else if (w_do_push && (empty || (w_do_pop && (r_count == COUNT_ONE)))) begin
            r_dout <= din;
        end
    end

endmodule

// File: rtl/iir_out_decim.sv
// ---------------------------------------------------------------------------
// iir_out_decim
//
// Output stage behind the biquad cascade. Averages blocks of `decim` input
// samples (accumulate-and-dump), saturates each average to `out_width` bits
// and buffers it in a FIFO drained over a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   qualifies y_in
//   y_in       signed sample from the last biquad section
//   out_ready  consumer takes out_data this cycle
//   clr_flags  synchronous clear of both sticky flags
//   out_valid  FIFO holds at least one result
//   out_data   signed head-of-FIFO result (first-word-fall-through)
//   sat_flag   sticky: a block result was clamped
//   ovf_flag   sticky: a block result was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module iir_out_decim
    import iir_out_decim_pkg::*;
#(
    parameter int bitwidth   = 32,
    parameter int out_width  = 16,
    parameter int decim      = 4,
    parameter int fifo_depth = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [bitwidth-1:0]  y_in,
    input  logic                        out_ready,
    input  logic                        clr_flags,
    output logic                        out_valid,
    output logic signed [out_width-1:0] out_data,
    output logic                        sat_flag,
    output logic                        ovf_flag
);

    localparam int SHIFT = clog2(decim);
    // The accumulator grows by log2(decim) bits so a full block can never
    // overflow it.
    localparam int AW    = bitwidth + SHIFT;
    localparam int CW    = (SHIFT > 0) ? SHIFT : 1;
    localparam int FCW   = clog2(fifo_depth) + 1;

    localparam logic signed [AW-1:0] SAT_HI     = AW'(sat_max(out_width));
    localparam logic signed [AW-1:0] SAT_LO     = AW'(sat_min(out_width));
    localparam logic [CW-1:0]        LAST_COUNT = CW'(decim - 1);

    logic signed [AW-1:0]        r_acc;
    logic [CW-1:0]               r_count;
    logic                        r_sat;
    logic                        r_ovf;

    logic signed [AW-1:0]        w_y_ext;
    logic signed [AW-1:0]        w_sum;
    logic signed [AW-1:0]        w_res;
    logic signed [out_width-1:0] w_sat_val;
    logic                        w_clamp;
    logic                        w_dump;
    logic                        w_pop;
    logic                        w_drop;
    logic                        w_full;
    logic                        w_empty;
    logic [FCW-1:0]              w_fifo_count;
    logic [out_width-1:0]        w_fifo_dout;

    assign w_y_ext = AW'(y_in);
    assign w_sum   = r_acc + w_y_ext;
    // Arithmetic shift gives the floor of the block average, also for
    // negative sums.
    assign w_res   = w_sum >>> SHIFT;
    assign w_dump  = in_valid && (r_count == LAST_COUNT);

    // Clamp the block average into the output word.
    always_comb begin
        w_sat_val = w_res[out_width-1:0];
        w_clamp   = 1'b0;
        if (w_res > SAT_HI) begin
            w_sat_val = SAT_HI[out_width-1:0];
            w_clamp   = 1'b1;
        end else if (w_res < SAT_LO) begin
            w_sat_val = SAT_LO[out_width-1:0];
            w_clamp   = 1'b1;
        end
    end

    // Accumulate valid samples; on the last sample of a block the sum is
    // consumed by the dump and the accumulator restarts from zero. Idle
    // cycles leave the partial block untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (in_valid) begin
            if (w_dump) begin
                r_acc   <= '0;
                r_count <= '0;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign w_pop  = out_ready && !w_empty;
    // A dump into a full FIFO is lost unless the consumer frees a slot on
    // the same edge.
    assign w_drop = w_dump && w_full && !w_pop;

    // Sticky flags: a set event on the same edge beats the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (w_dump && w_clamp) begin
                r_sat <= 1'b1;
            end else if (clr_flags) begin
                r_sat <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_flags) begin
                r_ovf <= 1'b0;
            end
        end
    end

    iir_sync_fifo #(
        .WIDTH (out_width),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_dump),
        .pop   (w_pop),
        .din   (w_sat_val),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign out_valid = (w_fifo_count != '0);
    assign out_data  = $signed(w_fifo_dout);
    assign sat_flag  = r_sat;
    assign ovf_flag  = r_ovf;

endmodule

// File: tb/tb_iir_out_decim.sv
// ---------------------------------------------------------------------------
// tb_iir_out_decim
//
// Self-checking bench for iir_out_decim (bitwidth 32, out_width 16, decim 4,
// fifo_depth 8). A queue-level reference model averages each block with
// integer floor division, clamps it and keeps the expected FIFO contents;
// every step compares out_valid, out_data and both flags with the model.
// Inputs change 1 ns after a rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iir_out_decim;

    localparam int     DECIM   = 4;
    localparam int     DEPTH   = 8;
    localparam longint OUT_MAX = 32767;
    localparam longint OUT_MIN = -32768;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [31:0] y_in;
    logic               out_ready;
    logic               clr_flags;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               sat_flag;
    logic               ovf_flag;

    int errors = 0;
    int checks = 0;

    longint             mAcc;
    int                 mCnt;
    int                 mQ[$];
    logic signed [15:0] mData;
    bit                 mSat;
    bit                 mOvf;

    iir_out_decim #(
        .bitwidth   (32),
        .out_width  (16),
        .decim      (DECIM),
        .fifo_depth (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .y_in      (y_in),
        .out_ready (out_ready),
        .clr_flags (clr_flags),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sat_flag  (sat_flag),
        .ovf_flag  (ovf_flag)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic signed [31:0] obs,
                              input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, "_valid"}, out_valid, (mQ.size() != 0));
        checkValue({tag, "_data"},  out_data,  mData);
        checkValue({tag, "_sat"},   sat_flag,  mSat);
        checkValue({tag, "_ovf"},   ovf_flag,  mOvf);
    endtask

    task automatic modelReset();
        mAcc  = 0;
        mCnt  = 0;
        mQ.delete();
        mData = '0;
        mSat  = 1'b0;
        mOvf  = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelEdge();
        bit     popNow;
        bit     pushNow;
        bit     setSat;
        bit     setOvf;
        longint avg;
        popNow  = (mQ.size() != 0) && out_ready;
        pushNow = 1'b0;
        setSat  = 1'b0;
        setOvf  = 1'b0;
        avg     = 0;
        if (in_valid) begin
            mAcc += longint'(y_in);
            mCnt++;
            if (mCnt == DECIM) begin
                avg = mAcc / DECIM;
                if ((mAcc % DECIM) != 0 && mAcc < 0) avg -= 1;
                if (avg > OUT_MAX) begin
                    avg    = OUT_MAX;
                    setSat = 1'b1;
                end else if (avg < OUT_MIN) begin
                    avg    = OUT_MIN;
                    setSat = 1'b1;
                end
                pushNow = 1'b1;
                mAcc    = 0;
                mCnt    = 0;
            end
        end
        if (popNow) void'(mQ.pop_front());
        if (pushNow) begin
            if (mQ.size() < DEPTH) mQ.push_back(int'(avg));
            else setOvf = 1'b1;
        end
        if (setSat) mSat = 1'b1;
        else if (clr_flags) mSat = 1'b0;
        if (setOvf) mOvf = 1'b1;
        else if (clr_flags) mOvf = 1'b0;
        if (mQ.size() != 0) mData = 16'(mQ[0]);
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare.
    task automatic applyStimulus(input string tag, input bit v, input int y,
                                 input bit rdy, input bit clr);
        in_valid  = v;
        y_in      = y;
        out_ready = rdy;
        clr_flags = clr;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    // Assert reset between edges, check the outputs clear without a clock
    // edge, hold it for two edges, then release.
    task automatic doReset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, "_async"});
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput({tag, "_held"});
        rst = 1'b1;
    endtask

    task automatic feedBlock(input string tag, input int y, input bit rdy);
        for (int i = 0; i < DECIM; i++) applyStimulus(tag, 1'b1, y, rdy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        y_in      = '0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        doReset("init");

        // Reset hit while a stream is active and results are buffered.
        for (int i = 0; i < 10; i++)
            applyStimulus("t1_pre", 1'b1, int'($urandom_range(0, 2000)), 1'b0, 1'b0);
        in_valid = 1'b1;
        doReset("t1_rst");

        // Back-to-back block of 100..400 averages to 250.
        for (int v = 100; v <= 400; v += 100) applyStimulus("t2", 1'b1, v, 1'b1, 1'b0);
        checkValue("t2_avg_data", out_data, 250);
        checkValue("t2_avg_valid", out_valid, 1);
        applyStimulus("t2_pop", 1'b0, 0, 1'b1, 1'b0);
        checkValue("t2_after_pop_valid", out_valid, 0);

        // Same block with idle cycles between the samples.
        for (int v = 100; v <= 400; v += 100) begin
            applyStimulus("t2g_gap", 1'b0, 7, 1'b1, 1'b0);
            applyStimulus("t2g", 1'b1, v, 1'b1, 1'b0);
        end
        checkValue("t2g_avg_data", out_data, 250);
        applyStimulus("t2g_pop", 1'b0, 0, 1'b1, 1'b0);

        // Floor rounding of a negative average.
        applyStimulus("t3", 1'b1, -1, 1'b1, 1'b0);
        applyStimulus("t3", 1'b1, -1, 1'b1, 1'b0);
        applyStimulus("t3", 1'b1, -1, 1'b1, 1'b0);
        applyStimulus("t3", 1'b1, -2, 1'b1, 1'b0);
        checkValue("t3_floor_data", out_data, -2);
        checkValue("t3_sat", sat_flag, 0);

        // Saturation at both limits, clear, and set-beats-clear.
        feedBlock("t4_hi", 40000, 1'b1);
        checkValue("t4_hi_data", out_data, 32767);
        checkValue("t4_hi_sat", sat_flag, 1);
        feedBlock("t4_lo", -40000, 1'b1);
        checkValue("t4_lo_data", out_data, -32768);
        applyStimulus("t4_clr", 1'b0, 0, 1'b1, 1'b1);
        checkValue("t4_clr_sat", sat_flag, 0);
        for (int i = 0; i < DECIM - 1; i++) applyStimulus("t4_race", 1'b1, 40000, 1'b1, 1'b0);
        applyStimulus("t4_race_dump", 1'b1, 40000, 1'b1, 1'b1);
        checkValue("t4_race_sat", sat_flag, 1);
        applyStimulus("t4_clr2", 1'b0, 0, 1'b1, 1'b1);

        // Overflow: nine blocks into an eight-entry FIFO, then drain in order.
        for (int k = 1; k <= 9; k++) feedBlock("t5_fill", k, 1'b0);
        checkValue("t5_ovf", ovf_flag, 1);
        for (int k = 1; k <= 8; k++) begin
            checkValue("t5_drain_data", out_data, k);
            applyStimulus("t5_drain", 1'b0, 0, 1'b1, 1'b0);
        end
        checkValue("t5_empty_valid", out_valid, 0);
        checkValue("t5_hold_data", out_data, 8);
        applyStimulus("t5_clr", 1'b0, 0, 1'b0, 1'b1);
        checkValue("t5_clr_ovf", ovf_flag, 0);

        // Full FIFO with a push and pop on the same edge: nothing is lost.
        for (int k = 11; k <= 18; k++) feedBlock("t5_full", k, 1'b0);
        for (int i = 0; i < DECIM - 1; i++) applyStimulus("t5_pp", 1'b1, 19, 1'b0, 1'b0);
        applyStimulus("t5_pp_dump", 1'b1, 19, 1'b1, 1'b0);
        checkValue("t5_pp_ovf", ovf_flag, 0);
        checkValue("t5_pp_head", out_data, 12);
        for (int i = 0; i < DEPTH; i++) applyStimulus("t5_pp_drain", 1'b0, 0, 1'b1, 1'b0);
        checkValue("t5_pp_last", out_data, 19);
        checkValue("t5_pp_empty", out_valid, 0);

        // Partial block discarded by a reset.
        applyStimulus("t6_part", 1'b1, 1000, 1'b0, 1'b0);
        applyStimulus("t6_part", 1'b1, 1000, 1'b0, 1'b0);
        doReset("t6_rst");
        feedBlock("t6_blk", 8, 1'b0);
        checkValue("t6_data", out_data, 8);
        checkValue("t6_valid", out_valid, 1);
        applyStimulus("t6_pop", 1'b0, 0, 1'b1, 1'b0);
        checkValue("t6_single", out_valid, 0);

        // Randomized traffic with occasional full-range samples and clears.
        for (int n = 0; n < 400; n++) begin
            bit v;
            bit rdy;
            bit clr;
            int y;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) y = int'($urandom());
            else y = int'($urandom_range(0, 200000)) - 100000;
            applyStimulus("rnd", v, y, rdy, clr);
            if (n == 200) doReset("rnd_rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
